// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each cycle grants up to NUM_LANES eligible requesters in
// round-robin order and registers their {data, tag} onto packed CDB lanes.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_serialized,
    input  logic [NUM_REQ*TAG_W-1:0]      req_tag_serialized,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_LANES*DATA_W-1:0]   CDB_data_serialized,
    output logic [NUM_LANES*TAG_W-1:0]    CDB_tag_serialized,
    output logic                          proto_err
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

    logic [DATA_W-1:0]            req_data [NUM_REQ];
    logic [TAG_W-1:0]             req_tag  [NUM_REQ];
    logic [NUM_REQ-1:0]           eligible;
    logic [NUM_REQ-1:0]           bad_tag;

    logic [PTR_W-1:0]             rr_ptr;
    logic [PTR_W-1:0]             rr_ptr_nxt;
    logic [PTR_W-1:0]             scan_idx;
    logic [PTR_W-1:0]             last_win;
    logic [CNT_W-1:0]             win_cnt;
    logic [CNT_W-1:0]             rank     [NUM_REQ];
    logic [NUM_REQ-1:0]           grant_c;
    logic [NUM_LANES*DATA_W-1:0]  cdb_data_nxt;
    logic [NUM_LANES*TAG_W-1:0]   cdb_tag_nxt;

    // Unpack requester slices (requester 0 sits in the MSBs) and qualify them.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            req_data[r] = req_data_serialized[(NUM_REQ-1-r)*DATA_W +: DATA_W];
            req_tag[r]  = req_tag_serialized[(NUM_REQ-1-r)*TAG_W +: TAG_W];
            eligible[r] = en & req_valid[r] & req_tag[r][TAG_W-1];
            bad_tag[r]  = req_valid[r] & ~req_tag[r][TAG_W-1];
        end
    end

    // Round-robin scan from rr_ptr; the k-th winner in scan order takes lane k.
    always_comb begin
        grant_c  = '0;
        win_cnt  = '0;
        last_win = rr_ptr;
        scan_idx = rr_ptr;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            rank[r] = '0;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (eligible[scan_idx] && (win_cnt < CNT_W'(NUM_LANES))) begin
                grant_c[scan_idx] = 1'b1;
                rank[scan_idx]    = win_cnt;
                last_win          = scan_idx;
                win_cnt           = win_cnt + CNT_W'(1);
            end
        end

        if (win_cnt == '0) begin
            rr_ptr_nxt = rr_ptr;
        end else if (last_win == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = last_win + PTR_W'(1);
        end
    end

    // Lane steering; lanes without a winner stay all-zero (idle).
    always_comb begin
        cdb_data_nxt = '0;
        cdb_tag_nxt  = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                if (grant_c[r] && (rank[r] == CNT_W'(k))) begin
                    cdb_data_nxt[(NUM_LANES-1-k)*DATA_W +: DATA_W] = req_data[r];
                    cdb_tag_nxt[(NUM_LANES-1-k)*TAG_W +: TAG_W]    = req_tag[r];
                end
            end
        end
    end

    assign req_grant = reset ? '0 : grant_c;

    // With en low there are no winners, so the lanes load idle and rr_ptr holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr              <= '0;
            CDB_data_serialized <= '0;
            CDB_tag_serialized  <= '0;
            proto_err           <= 1'b0;
        end else begin
            rr_ptr              <= rr_ptr_nxt;
            CDB_data_serialized <= cdb_data_nxt;
            CDB_tag_serialized  <= cdb_tag_nxt;
            if (|bad_tag) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the NUM_LANES-wide common data bus (CDB) among NUM_REQ functional-unit requesters, e.g. the adder, multiplier and memory reservation stations.
- Each cycle it grants up to NUM_LANES requesters in round-robin order and registers the winners' {data, tag} onto the CDB lanes.
- Reservation stations and the regfile snoop these lanes.
- Replaces free-running offload: a requester retires its entry only on grant.

Parameters:
- NUM_REQ, 4, number of requesting units.
- NUM_LANES, 3, number of CDB lanes.
- DATA_W, 32, data width per lane.
- TAG_W, 8, tag width; bit TAG_W-1 is the tag-valid bit.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  global enable.
- req_valid  input  NUM_REQ  bit r set: requester r holds a result.
- req_data_serialized  input  NUM_REQ*DATA_W  requester r's data; requester 0 in the MSBs.
- req_tag_serialized  input  NUM_REQ*TAG_W  requester r's tag; requester 0 in the MSBs.
- req_grant  output  NUM_REQ  combinational grant; result is captured this cycle.
- CDB_data_serialized  output  NUM_LANES*DATA_W  registered; lane 0 in the MSBs.
- CDB_tag_serialized  output  NUM_LANES*TAG_W  registered; lane 0 in the MSBs; idle lane = all zeros.
- proto_err  output  1  sticky: a request arrived with tag bit TAG_W-1 = 0.

Behaviour:
- Reset (asynchronous, any time, including mid-broadcast):
  - All CDB data/tag registers = 0; rr_ptr = 0; proto_err = 0.
  - req_grant = 0 while reset is high.
- Eligibility:
  - eligible[r] = en & req_valid[r] & req_tag[r][TAG_W-1].
  - req_valid[r] with tag bit clear → never granted; sets proto_err on the next edge.
  - proto_err clears only on reset.
- Arbitration (combinational, each cycle):
  - Scan r = rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first NUM_LANES eligible requesters are granted.
  - The k-th winner in scan order is assigned lane k; lanes are packed from lane 0 upward.
  - Fewer winners than lanes → the upper lanes are idle.
- Handshake:
  - req_grant[r] = 1 means the result is consumed at this clock edge.
  - The requester must drop or replace its request on the next cycle.
  - Ungranted requesters hold req_valid/data/tag stable.
  - No request is ever granted twice for one capture.
- CDB output (registered, 1-cycle latency):
  - On each edge with en = 1, lane k ← {data, tag} of winner k, or 0/0 if lane k has no winner.
  - Each lane is valid for exactly one cycle per grant. Lanes never hold or repeat.
- Pointer update: after a cycle with ≥1 grant, rr_ptr ← (index of last winner + 1) mod NUM_REQ. With no grants, rr_ptr holds.
- Fairness: with all requesters continuously eligible, every requester is granted at least once per ceil(NUM_REQ/NUM_LANES) cycles.
- en = 0:
  - req_grant = 0; rr_ptr holds.
  - CDB registers load idle (all zeros), so no stale result is rebroadcast.
- Duplicate tags: the arbiter does not check tag uniqueness; two requesters with the same tag both broadcast in lane order.
- Width rules: lane slices are fixed at DATA_W/TAG_W; no arithmetic on the data.
- NUM_LANES ≥ NUM_REQ: all eligible requesters are granted every cycle; rr_ptr updates anyway.

Test Plan:
1. Reset mid-traffic:
   - Stimulus: all 4 requesters valid, tags 0xA0–0xA3; assert reset asynchronously between edges.
   - Response: CDB tags go 0 immediately; req_grant = 0; after release the first grants are req 0,1,2 (rr_ptr = 0).
2. Round-robin rotation:
   - Stimulus: 4 requesters continuously valid with tags 0xC0–0xC3, data 0x10–0x13.
   - Response, cycle 1: grants 0,1,2; lanes next cycle = {0xC0/0x10, 0xC1/0x11, 0xC2/0x12}.
   - Response, cycle 2: rr_ptr = 3; grants 3,0,1; lane 0 = 0xC3/0x13.
3. Sparse packing:
   - Stimulus: only req 2 valid, tag 0xD2, data 0xDEADBEEF.
   - Response: grant[2] = 1; next cycle lane 0 = 0xD2/0xDEADBEEF; lanes 1–2 tag 0; the following cycle all lanes are idle.
4. Protocol error:
   - Stimulus: req 1 valid with tag 0x45 (bit 7 clear).
   - Response: never granted; proto_err = 1 from the next edge and stays 1 after req_valid drops.
5. Enable gating:
   - Stimulus: en = 0 for 3 cycles with req 0,3 valid.
   - Response: no grants; CDB tags all 0; rr_ptr unchanged.
   - Then en = 1: grants 0 and 3 in the same cycle, on lanes 0 and 1 respectively.
6. Wrap-around:
   - Stimulus: rr_ptr = 3 (after granting 0,1,2), then only req 3 and 0 valid.
   - Response: lane 0 = req 3, lane 1 = req 0; rr_ptr ← 1.
